// File: rtl/md5_pkg.sv
// md5_pkg: shared MD5 constants and helpers.
//   - FSM state type and encodings
//   - IV words, 64-entry K table, 64-entry rotate table
//   - round function F/G/H/I and message-index schedule g(i)
package md5_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_FINAL = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    localparam logic [31:0] MD5_K [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    localparam logic [4:0] MD5_S [64] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
    };

    // F, G, H, I selected by round (step index / 16)
    function automatic logic [31:0] md5_round_fn(input logic [5:0] idx,
                                                 input logic [31:0] b,
                                                 input logic [31:0] c,
                                                 input logic [31:0] d);
        logic [31:0] f;
        case (idx[5:4])
            2'd0:    f = (b & c) | (~b & d);
            2'd1:    f = (b & d) | (c & ~d);
            2'd2:    f = b ^ c ^ d;
            default: f = c ^ (b | ~d);
        endcase
        return f;
    endfunction

    // Message word index; 4-bit arithmetic gives the mod-16 for free
    function automatic logic [3:0] md5_msg_idx(input logic [5:0] idx);
        logic [3:0] i;
        logic [3:0] g;
        i = idx[3:0];
        case (idx[5:4])
            2'd0:    g = i;
            2'd1:    g = i * 4'd5 + 4'd1;
            2'd2:    g = i * 4'd3 + 4'd5;
            default: g = i * 4'd7;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/md5_step.sv
// md5_step: one combinational MD5 step.
//   i_a..i_d : working words in
//   i_m      : message word M[g(i)] for this step
//   i_idx    : step index 0..63
//   o_a..o_d : working words out
module md5_step
    import md5_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic [31:0] i_d,
    input  logic [31:0] i_m,
    input  logic [5:0]  i_idx,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_c,
    output logic [31:0] o_d
);

    logic [31:0] w_f;
    logic [31:0] w_sum;
    logic [31:0] w_rot;
    logic [4:0]  w_s;

    assign w_f   = md5_round_fn(i_idx, i_b, i_c, i_d);
    assign w_sum = i_a + w_f + MD5_K[i_idx] + i_m;
    assign w_s   = MD5_S[i_idx];
    // rotate amount is never 0, so the right shift stays below 32
    assign w_rot = (w_sum << w_s) | (w_sum >> (6'd32 - {1'b0, w_s}));

    assign o_a = i_d;
    assign o_b = i_b + w_rot;
    assign o_c = i_b;
    assign o_d = i_c;

endmodule

// File: rtl/md5_iter_core.sv
// md5_iter_core: iterative MD5 block compressor, STEPS_PER_CYCLE steps/clock.
//   clk, reset        : clock, async active-high reset
//   en                : global enable (0 freezes everything)
//   mesg, valid_in    : 512-bit padded block and request
//   first_in          : 1 = start from IV, 0 = chain from last digest
//   ready             : idle, block can be accepted
//   a_out..d_out      : digest words (MD5 little-endian word form)
//   valid_out, ack    : digest valid until acknowledged
module md5_iter_core
    import md5_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [511:0] mesg,
    input  logic         valid_in,
    input  logic         first_in,
    output logic         ready,
    output logic [31:0]  a_out,
    output logic [31:0]  b_out,
    output logic [31:0]  c_out,
    output logic [31:0]  d_out,
    output logic         valid_out,
    input  logic         ack
);

    localparam int CYCLES = 64 / STEPS_PER_CYCLE;

    if (CYCLES * STEPS_PER_CYCLE != 64 || STEPS_PER_CYCLE > 16 ||
        (STEPS_PER_CYCLE & (STEPS_PER_CYCLE - 1)) != 0) begin : g_bad_param
        $error("md5_iter_core: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_t       r_state;
    logic [6:0]   r_cnt;
    logic [511:0] r_mesg;
    logic [31:0]  r_a, r_b, r_c, r_d;
    logic [31:0]  r_ch_a, r_ch_b, r_ch_c, r_ch_d;
    logic [31:0]  r_st_a, r_st_b, r_st_c, r_st_d;
    logic [31:0]  r_dg_a, r_dg_b, r_dg_c, r_dg_d;

    logic [31:0]  w_mw [16];
    logic [31:0]  w_ca [STEPS_PER_CYCLE+1];
    logic [31:0]  w_cb [STEPS_PER_CYCLE+1];
    logic [31:0]  w_cc [STEPS_PER_CYCLE+1];
    logic [31:0]  w_cd [STEPS_PER_CYCLE+1];
    logic [6:0]   w_cnt_nxt;
    logic [31:0]  w_in_a, w_in_b, w_in_c, w_in_d;

    // byte 0 of each word sits in the top byte of mesg; MD5 wants it low
    for (genvar k = 0; k < 16; k++) begin : g_mw
        logic [31:0] w_raw;
        assign w_raw   = r_mesg[511-32*k -: 32];
        assign w_mw[k] = {w_raw[7:0], w_raw[15:8], w_raw[23:16], w_raw[31:24]};
    end

    assign w_ca[0] = r_a;
    assign w_cb[0] = r_b;
    assign w_cc[0] = r_c;
    assign w_cd[0] = r_d;

    for (genvar j = 0; j < STEPS_PER_CYCLE; j++) begin : g_step
        logic [5:0] w_idx;
        assign w_idx = r_cnt[5:0] + 6'(j);
        md5_step u_step (
            .i_a   (w_ca[j]),
            .i_b   (w_cb[j]),
            .i_c   (w_cc[j]),
            .i_d   (w_cd[j]),
            .i_m   (w_mw[md5_msg_idx(w_idx)]),
            .i_idx (w_idx),
            .o_a   (w_ca[j+1]),
            .o_b   (w_cb[j+1]),
            .o_c   (w_cc[j+1]),
            .o_d   (w_cd[j+1])
        );
    end

    assign w_cnt_nxt = r_cnt + 7'(STEPS_PER_CYCLE);

    // reset loads the stored digest with IV, so first_in=0 also starts from IV
    assign w_in_a = first_in ? IV_A : r_st_a;
    assign w_in_b = first_in ? IV_B : r_st_b;
    assign w_in_c = first_in ? IV_C : r_st_c;
    assign w_in_d = first_in ? IV_D : r_st_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mesg  <= '0;
            {r_a, r_b, r_c, r_d}             <= '0;
            {r_ch_a, r_ch_b, r_ch_c, r_ch_d} <= '0;
            {r_st_a, r_st_b, r_st_c, r_st_d} <= {IV_A, IV_B, IV_C, IV_D};
            {r_dg_a, r_dg_b, r_dg_c, r_dg_d} <= '0;
        end else if (en) begin
            case (r_state)
                ST_IDLE: if (valid_in) begin
                    r_mesg  <= mesg;
                    {r_ch_a, r_ch_b, r_ch_c, r_ch_d} <= {w_in_a, w_in_b, w_in_c, w_in_d};
                    {r_a, r_b, r_c, r_d}             <= {w_in_a, w_in_b, w_in_c, w_in_d};
                    r_cnt   <= '0;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_a   <= w_ca[STEPS_PER_CYCLE];
                    r_b   <= w_cb[STEPS_PER_CYCLE];
                    r_c   <= w_cc[STEPS_PER_CYCLE];
                    r_d   <= w_cd[STEPS_PER_CYCLE];
                    r_cnt <= w_cnt_nxt;
                    if (w_cnt_nxt == 7'd64) r_state <= ST_FINAL;
                end
                ST_FINAL: begin
                    r_dg_a  <= r_ch_a + r_a;
                    r_dg_b  <= r_ch_b + r_b;
                    r_dg_c  <= r_ch_c + r_c;
                    r_dg_d  <= r_ch_d + r_d;
                    r_st_a  <= r_ch_a + r_a;
                    r_st_b  <= r_ch_b + r_b;
                    r_st_c  <= r_ch_c + r_c;
                    r_st_d  <= r_ch_d + r_d;
                    r_state <= ST_DONE;
                end
                ST_DONE: if (ack) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready     = (r_state == ST_IDLE);
    assign valid_out = (r_state == ST_DONE);
    assign a_out     = r_dg_a;
    assign b_out     = r_dg_b;
    assign c_out     = r_dg_c;
    assign d_out     = r_dg_d;

endmodule

// File: tb/tb_md5_iter_core.sv
// tb_md5_iter_core: directed bench with a digest scoreboard and an
// independent MD5 reference model (K derived from sin()).
module tb_md5_iter_core;

    logic         clk = 1'b0;
    logic         reset, en, valid_in, first_in, ack;
    logic [511:0] mesg;
    logic         ready, valid_out;
    logic [31:0]  a_out, b_out, c_out, d_out;

    logic         x_vin, x_ack;
    logic [3:0]   x_ready, x_vout;
    logic [3:0][31:0] x_a, x_b, x_c, x_d;

    always #5 clk = ~clk;

    md5_iter_core #(.STEPS_PER_CYCLE(4)) dut (
        .clk(clk), .reset(reset), .en(en), .mesg(mesg), .valid_in(valid_in),
        .first_in(first_in), .ready(ready), .a_out(a_out), .b_out(b_out),
        .c_out(c_out), .d_out(d_out), .valid_out(valid_out), .ack(ack)
    );

    for (genvar g = 0; g < 4; g++) begin : g_x
        localparam int SPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        md5_iter_core #(.STEPS_PER_CYCLE(SPC)) u_x (
            .clk(clk), .reset(reset), .en(en), .mesg(mesg), .valid_in(x_vin),
            .first_in(first_in), .ready(x_ready[g]), .a_out(x_a[g]), .b_out(x_b[g]),
            .c_out(x_c[g]), .d_out(x_d[g]), .valid_out(x_vout[g]), .ack(x_ack)
        );
    end

    typedef struct {
        logic [127:0] dig;
        int           lat;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [127:0] IV128    = 128'h67452301_efcdab89_98badcfe_10325476;
    localparam logic [127:0] D_HELLO  = 128'hb18d0ab1_4175e064_9ba9b705_e53f2ee7;
    localparam logic [127:0] D_FOX    = 128'h9d7d109e_82b62b37_351dd86b_d619a442;
    localparam logic [127:0] D_EMPTY  = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_k(input int i);
        real r;
        r = $sin(real'(i + 1));
        if (r < 0.0) r = -r;
        return 32'(longint'($floor(r * 4294967296.0)));
    endfunction

    function automatic logic [127:0] ref_md5(input logic [127:0] chain, input logic [511:0] blk);
        int rs [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};
        logic [31:0] m [16];
        logic [31:0] w, a, b, c, d, f, t;
        int gi, sh;
        for (int k = 0; k < 16; k++) begin
            w    = blk[511-32*k -: 32];
            m[k] = {w[7:0], w[15:8], w[23:16], w[31:24]};
        end
        {a, b, c, d} = chain;
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0:       begin f = (b & c) | (~b & d); gi = i;                end
                1:       begin f = (d & b) | (~d & c); gi = (5 * i + 1) % 16; end
                2:       begin f = b ^ c ^ d;          gi = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d);       gi = (7 * i) % 16;     end
            endcase
            t  = a + f + ref_k(i) + m[gi];
            sh = rs[i / 16][i % 4];
            t  = (t << sh) | (t >> (32 - sh));
            a  = d; d = c; c = b; b = b + t;
        end
        return {chain[127:96] + a, chain[95:64] + b, chain[63:32] + c, chain[31:0] + d};
    endfunction

    function automatic logic [511:0] pad_str(input string s);
        logic [511:0] blk;
        logic [63:0]  bits;
        blk  = '0;
        for (int k = 0; k < s.len(); k++) blk[511-8*k -: 8] = s[k];
        blk[511-8*s.len() -: 8] = 8'h80;
        bits = 64'(s.len()) * 64'd8;
        for (int k = 0; k < 8; k++) blk[511-8*(56+k) -: 8] = bits[8*k +: 8];
        return blk;
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic send(input logic [511:0] blk, input logic fst, input logic [127:0] expv,
                        input int lat, input string tag);
        check({tag, "_ready"}, {127'd0, ready}, 128'd1);
        sb.push_back('{expv, lat, tag});
        mesg     = blk;
        first_in = fst;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic wait_done(input bit toggle, input bit noise, output logic [127:0] dig);
        int   n   = 0;
        int   tot = 0;
        bit   got = 0;
        exp_t e;
        for (int c = 0; c < 300 && !got; c++) begin
            if (noise) begin
                valid_in = 1'b1;
                ack      = 1'b1;
                mesg     = {16{$urandom}};
            end
            if (toggle) en = ~en;
            @(negedge clk);
            tot++;
            if (en) n++;
            if (valid_out) got = 1;
        end
        valid_in = 1'b0;
        ack      = 1'b0;
        en       = 1'b1;
        e = sb.pop_front();
        dig = e.dig;
        check({e.tag, "_seen"}, {127'd0, got}, 128'd1);
        check({e.tag, "_lat"}, 128'(n), 128'(e.lat));
        if (toggle) check({e.tag, "_edges"}, 128'(tot), 128'(2 * e.lat));
        check({e.tag, "_dig"}, {a_out, b_out, c_out, d_out}, e.dig);
    endtask

    task automatic retire(input bit with_vin, input string tag);
        ack = 1'b1;
        if (with_vin) begin
            valid_in = 1'b1;
            mesg     = pad_str("x");
        end
        @(negedge clk);
        ack      = 1'b0;
        valid_in = 1'b0;
        check({tag, "_retire"}, {126'd0, ready, valid_out}, {126'd0, 2'b10});
    endtask

    initial begin
        logic [127:0] dig, prev;
        logic [511:0] blk;
        bit           seen;
        int           xl [4];
        int           xexp [4] = '{65, 33, 9, 5};

        reset = 1'b1; en = 1'b1; valid_in = 1'b0; first_in = 1'b0; ack = 1'b0;
        x_vin = 1'b0; x_ack = 1'b0; mesg = '0;
        repeat (2) @(negedge clk);
        check("rst_ready_valid", {126'd0, ready, valid_out}, {126'd0, 2'b10});
        check("rst_digest", {a_out, b_out, c_out, d_out}, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // Hello World, then hold ack off and retire with a concurrent valid_in
        send(pad_str("Hello World"), 1'b1, D_HELLO, 17, "hello");
        wait_done(1'b0, 1'b0, dig);
        repeat (10) @(negedge clk);
        check("hello_hold_valid", {127'd0, valid_out}, 128'd1);
        check("hello_hold_dig", {a_out, b_out, c_out, d_out}, dig);
        retire(1'b1, "hello");

        // quick brown fox with en toggling every cycle
        send(pad_str("The quick brown fox jumps over the lazy dog"), 1'b1, D_FOX, 17, "fox");
        wait_done(1'b1, 1'b0, dig);
        retire(1'b0, "fox");

        // two-block message, valid_in/ack noise while busy
        for (int k = 0; k < 64; k++) blk[511-8*k -: 8] = 8'(k);
        prev = ref_md5(IV128, blk);
        send(blk, 1'b1, prev, 17, "blk1");
        wait_done(1'b0, 1'b1, dig);
        retire(1'b0, "blk1");
        blk = '0;
        blk[511 -: 8]        = 8'h80;
        blk[511-8*57 -: 8]   = 8'h02;
        prev = ref_md5(prev, blk);
        send(blk, 1'b0, prev, 17, "blk2");
        wait_done(1'b0, 1'b0, dig);
        retire(1'b0, "blk2");

        // random continuation block chained onto the previous digest
        for (int k = 0; k < 16; k++) blk[32*k +: 32] = $urandom;
        prev = ref_md5(prev, blk);
        send(blk, 1'b0, prev, 17, "rnd");
        wait_done(1'b0, 1'b0, dig);
        retire(1'b0, "rnd");

        // reset in the middle of RUN (after step 32)
        mesg = pad_str("The quick brown fox jumps over the lazy dog");
        first_in = 1'b1;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_ready_valid", {126'd0, ready, valid_out}, {126'd0, 2'b10});
        check("midrst_digest", {a_out, b_out, c_out, d_out}, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (valid_out) seen = 1;
        end
        check("midrst_no_valid", {127'd0, seen}, 128'd0);
        send(pad_str("Hello World"), 1'b0, D_HELLO, 17, "postrst");
        wait_done(1'b0, 1'b0, dig);
        retire(1'b0, "postrst");

        // empty string on the 1/2/8/16 steps-per-cycle variants
        mesg = pad_str("");
        first_in = 1'b1;
        x_vin = 1'b1;
        @(negedge clk);
        x_vin = 1'b0;
        xl = '{0, 0, 0, 0};
        for (int c = 1; c <= 100 && xl[0] == 0; c++) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) if (x_vout[g] && xl[g] == 0) xl[g] = c;
        end
        for (int g = 0; g < 4; g++) begin
            check($sformatf("empty_s%0d_lat", g), 128'(xl[g]), 128'(xexp[g]));
            check($sformatf("empty_s%0d_dig", g), {x_a[g], x_b[g], x_c[g], x_d[g]}, D_EMPTY);
        end
        x_ack = 1'b1;
        @(negedge clk);
        x_ack = 1'b0;
        check("empty_retire", {124'd0, x_ready}, 128'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
